// File: rtl/vga_scanout.sv
// vga_scanout: 160x120x3 framebuffer written by the drawing datapath and read
// back as a 640x480@60 VGA stream, each stored pixel shown as a 4x4 block.
// frame_start gives the animation one step per displayed frame.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] color,
  input  logic       writeEn,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam int         FB_DEPTH = 19200;

  logic        phase_q, phase_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        frame_start_q, frame_start_d;
  logic        vis_q, vis_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  logic        pix_en;
  logic        visible;
  logic        hs_raw;
  logic        vs_raw;
  logic        wr_ok;
  logic [14:0] wr_addr;
  logic [14:0] rd_addr;

  logic [2:0]  mem [0:FB_DEPTH-1];
  logic [2:0]  ram_rd_data;

  // Region decode and address generation straight from the current counters.
  always_comb begin
    pix_en  = phase_q;
    visible = (h_q < H_VIS) && (v_q < V_VIS);
    hs_raw  = !((h_q >= HS_START) && (h_q < HS_END));
    vs_raw  = !((v_q >= VS_START) && (v_q < VS_END));
    wr_ok   = writeEn && (x < 8'd160) && (y < 7'd120);
    wr_addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    rd_addr = {1'b0, v_q[8:2], 7'b0} + {3'b0, v_q[8:2], 5'b0} + {7'b0, h_q[9:2]};
  end

  // Next-state for the pixel phase, raster counters and aligned output stage.
  always_comb begin
    phase_d       = ~phase_q;
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    vis_d         = vis_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    if (pix_en) begin
      vis_d = visible;
      hs_d  = hs_raw;
      vs_d  = vs_raw;
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d           = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Timing and output-stage registers, restarted at (0,0) by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q       <= 1'b0;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      frame_start_q <= 1'b0;
      vis_q         <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      phase_q       <= phase_d;
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
      vis_q         <= vis_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  // Dual-port framebuffer: writes every clock, registered read on pix_en (old data on collision).
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_addr] <= color;
    end
    if (pix_en && visible) begin
      ram_rd_data <= mem[rd_addr];
    end
  end

  assign vga_r       = {8{ram_rd_data[2] & vis_q}};
  assign vga_g       = {8{ram_rd_data[1] & vis_q}};
  assign vga_b       = {8{ram_rd_data[0] & vis_q}};
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = vis_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = phase_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench for vga_scanout using a shrunken raster
// (48x22 pixel periods, 32x16 visible) so whole frames fit in a short run.
module tb_vga_scanout;

  localparam int HV = 32, HF = 4, HS = 6, HB = 6, HT = 48;
  localparam int VV = 16, VF = 2, VS = 2, VB = 2, VT = 22;
  localparam int F  = HT * VT;   // 1056 pixel periods per frame
  localparam int FC = 2 * F;     // 2112 clocks per frame

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] x = 8'd0;
  logic [6:0] y = 7'd0;
  logic [2:0] color = 3'd0;
  logic       writeEn = 1'b0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk, frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] fb_model [0:19199];

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .color(color), .writeEn(writeEn),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk),
    .frame_start(frame_start)
  );

  // 10 ns system clock.
  always #5 clock = ~clock;

  // Clock edges since the last edge at which reset was sampled low.
  always @(posedge clock) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Expected {r,g,b,hs,vs,blank_n,frame_start,vga_clk} just after edge n (n >= 2).
  function automatic logic [28:0] exp_out(input int n);
    int q, h, v;
    logic vis, hs, vs;
    logic [2:0] c;
    q   = n / 2 - 1;
    h   = q % HT;
    v   = (q / HT) % VT;
    vis = (h < HV) && (v < VV);
    hs  = !((h >= HV + HF) && (h < HV + HF + HS));
    vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    c   = vis ? fb_model[(v / 4) * 160 + h / 4] : 3'b000;
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs, vs, vis, (n % FC == 0), (n % 2 == 1)};
  endfunction

  // Advance to the falling edge after edge number target.
  task automatic wait_cycle(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 100000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != target) begin
      errors++;
      $display("[TB] FAIL wait_cycle: reached cycle %0d, wanted %0d", cyc, target);
    end
  endtask

  // One-clock pixel write; the bench framebuffer drops out-of-range writes.
  task automatic write_pixel(input int px, input int py, input logic [2:0] pc);
    x       = 8'(px);
    y       = 7'(py);
    color   = pc;
    writeEn = 1'b1;
    @(negedge clock);
    writeEn = 1'b0;
    if (px < 160 && py < 120) fb_model[py * 160 + px] = pc;
  endtask

  // Zero the part of the framebuffer the shrunken raster displays.
  task automatic clear_window();
    for (int wy = 0; wy < 4; wy++)
      for (int wx = 0; wx < 8; wx++)
        write_pixel(wx, wy, 3'b000);
  endtask

  task automatic test_reset();
    int first_fs, second_fs, pulses;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (vga_hs !== 1'b1) begin errors++; $display("[TB] FAIL reset_hs: got %b want 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1) begin errors++; $display("[TB] FAIL reset_vs: got %b want 1", vga_vs); end
    checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_blank: got %b want 0", vga_blank_n); end
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("[TB] FAIL reset_rgb: got %h want 000000", {vga_r, vga_g, vga_b}); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start: got %b want 0", frame_start); end
    checks++; if (vga_clk !== 1'b0) begin errors++; $display("[TB] FAIL reset_vga_clk: got %b want 0", vga_clk); end
    checks++; if (vga_sync_n !== 1'b0) begin errors++; $display("[TB] FAIL sync_n: got %b want 0", vga_sync_n); end
    reset = 1'b1;
    first_fs = -1; second_fs = -1; pulses = 0;
    repeat (2 * FC + 1) begin
      @(negedge clock);
      if (frame_start === 1'b1) begin
        pulses++;
        if (first_fs < 0) first_fs = cyc;
        else if (second_fs < 0) second_fs = cyc;
      end
    end
    checks++; if (first_fs != 2112) begin errors++; $display("[TB] FAIL first_frame_start: at %0d want 2112", first_fs); end
    checks++; if (second_fs != 4224) begin errors++; $display("[TB] FAIL second_frame_start: at %0d want 4224", second_fs); end
    checks++; if (pulses != 2) begin errors++; $display("[TB] FAIL frame_start_count: got %0d want 2", pulses); end
  endtask

  task automatic test_read_during_write();
    int k;
    k = cyc / FC + 1;
    wait_cycle(k * FC + 1);
    x = 8'd0; y = 7'd0; color = 3'b010; writeEn = 1'b1;
    @(negedge clock);
    writeEn = 1'b0;
    fb_model[0] = 3'b010;
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h000000) begin errors++; $display("[TB] FAIL rdw_old_data: got %h want 000000", {vga_r, vga_g, vga_b}); end
    checks++; if (vga_blank_n !== 1'b1) begin errors++; $display("[TB] FAIL rdw_blank: got %b want 1", vga_blank_n); end
    wait_cycle((k + 1) * FC + 2);
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h00FF00) begin errors++; $display("[TB] FAIL rdw_next_frame: got %h want 00ff00", {vga_r, vga_g, vga_b}); end
  endtask

  task automatic test_write_and_scan();
    int k, off;
    logic [28:0] e;
    write_pixel(0, 0, 3'b100);
    write_pixel(7, 3, 3'b011);
    write_pixel(159, 119, 3'b011);
    k = cyc / FC + 1;
    wait_cycle(k * FC + 2);
    repeat (FC) begin
      e = exp_out(cyc);
      checks++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, vga_clk} !== e) begin
        errors++;
        $display("[TB] FAIL scan_pixel cyc %0d: got %h want %h", cyc,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, vga_clk}, e);
      end
      off = cyc - k * FC;
      // (2,1) in the red block, (30,14) in the cyan block, (4,0) and (27,13) just outside them
      if (off == 102) begin
        checks++; if ({vga_r, vga_g, vga_b} !== 24'hFF0000) begin errors++; $display("[TB] FAIL red_block: got %h want ff0000", {vga_r, vga_g, vga_b}); end
      end
      if (off == 1406) begin
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h00FFFF) begin errors++; $display("[TB] FAIL cyan_block: got %h want 00ffff", {vga_r, vga_g, vga_b}); end
      end
      if (off == 10 || off == 1304) begin
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h000000) begin errors++; $display("[TB] FAIL block_edge off %0d: got %h want 000000", off, {vga_r, vga_g, vga_b}); end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_out_of_range();
    int k;
    logic [28:0] e;
    write_pixel(160, 0, 3'b111);
    write_pixel(0, 120, 3'b111);
    k = cyc / FC + 1;
    wait_cycle(k * FC + 2);
    repeat (FC) begin
      e = exp_out(cyc);
      checks++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, vga_clk} !== e) begin
        errors++;
        $display("[TB] FAIL oor_scan cyc %0d: got %h want %h", cyc,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, vga_clk}, e);
      end
      // screen (0,4) reads address 160
      if (cyc - k * FC == 386) begin
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h000000) begin errors++; $display("[TB] FAIL oor_addr160: got %h want 000000", {vga_r, vga_g, vga_b}); end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_sync_blank();
    int k, ln, vs_low, vs_bad, first_hs, first_vs;
    int hs_low [VT];
    int blank_hi [VT];
    foreach (hs_low[i]) begin hs_low[i] = 0; blank_hi[i] = 0; end
    vs_low = 0; vs_bad = 0; first_hs = -1; first_vs = -1;
    k = cyc / FC + 1;
    wait_cycle(k * FC + 2);
    repeat (FC) begin
      ln = ((cyc / 2 - 1) / HT) % VT;
      if (vga_hs === 1'b0) begin hs_low[ln]++; if (first_hs < 0) first_hs = cyc - k * FC; end
      if (vga_vs === 1'b0) begin
        vs_low++;
        if (first_vs < 0) first_vs = cyc - k * FC;
        if (ln < VV + VF || ln >= VV + VF + VS) vs_bad++;
      end
      if (vga_blank_n === 1'b1) blank_hi[ln]++;
      @(negedge clock);
    end
    for (int l = 0; l < VT; l++) begin
      checks++; if (hs_low[l] != 12) begin errors++; $display("[TB] FAIL hs_width line %0d: got %0d want 12", l, hs_low[l]); end
      checks++; if (blank_hi[l] != ((l < VV) ? 64 : 0)) begin errors++; $display("[TB] FAIL blank_width line %0d: got %0d want %0d", l, blank_hi[l], (l < VV) ? 64 : 0); end
    end
    checks++; if (vs_low != 192) begin errors++; $display("[TB] FAIL vs_width: got %0d want 192", vs_low); end
    checks++; if (vs_bad != 0) begin errors++; $display("[TB] FAIL vs_lines: got %0d stray clocks want 0", vs_bad); end
    // h reaches 36 at offset 72; line 18 starts at offset 1728
    checks++; if (first_hs != 74) begin errors++; $display("[TB] FAIL hs_start: got %0d want 74", first_hs); end
    checks++; if (first_vs != 1730) begin errors++; $display("[TB] FAIL vs_start: got %0d want 1730", first_vs); end
  endtask

  task automatic test_mid_frame_reset();
    int k;
    logic [28:0] e;
    k = cyc / FC + 1;
    // pixel period 421 = (h 37, v 8), inside hsync
    wait_cycle(k * FC + 844);
    checks++; if (vga_hs !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_hs: got %b want 0", vga_hs); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (vga_hs !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_hs: got %b want 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_vs: got %b want 1", vga_vs); end
    checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_blank: got %b want 0", vga_blank_n); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_frame_start: got %b want 0", frame_start); end
    checks++; if (vga_clk !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_vga_clk: got %b want 0", vga_clk); end
    reset = 1'b1;
    wait_cycle(2);
    checks++; if ({vga_r, vga_g, vga_b} !== 24'hFF0000) begin errors++; $display("[TB] FAIL mid_reset_pixel0: got %h want ff0000", {vga_r, vga_g, vga_b}); end
    repeat (FC) begin
      e = exp_out(cyc);
      checks++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, vga_clk} !== e) begin
        errors++;
        $display("[TB] FAIL restart_scan cyc %0d: got %h want %h", cyc,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, vga_clk}, e);
      end
      @(negedge clock);
    end
  endtask

  // Safety net in case a scenario stalls.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence.
  initial begin
    foreach (fb_model[i]) fb_model[i] = 3'b000;
    test_reset();
    clear_window();
    test_read_during_write();
    test_write_and_scan();
    test_out_of_range();
    test_sync_blank();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Framebuffer and VGA scan-out engine that receives pixel writes from the drawing/animation datapath (`x`, `y`, `color`, `writeEn` at 160x120, 3-bit colour) and reads them back as a 640x480@60 Hz VGA stream, replicating each stored pixel 4x4. It sits between the `top`/`datapath` animation logic and the board DAC. It also supplies a `frame_start` pulse so the animation can step once per frame instead of free-running a delay counter.

## Interface

Parameters:
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixel periods.
- `H_SYNC`, 96: hsync width, in pixel periods.
- `H_BACK`, 48: horizontal back porch, in pixel periods.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Ports:
- `clock` in 1: 50 MHz system clock.
- `reset` in 1: reset, synchronous, active-low.
- `x` in 8: write column, valid range 0..159.
- `y` in 7: write row, valid range 0..119.
- `color` in 3: write colour {R,G,B}.
- `writeEn` in 1: pixel write strobe, sampled every clock.
- `vga_r`, `vga_g`, `vga_b` out 8 each: colour channels; each is the corresponding stored bit replicated 8x.
- `vga_hs` out 1: hsync, active-low.
- `vga_vs` out 1: vsync, active-low.
- `vga_blank_n` out 1: 1 while in the visible region.
- `vga_sync_n` out 1: constant 0.
- `vga_clk` out 1: pixel clock, 25 MHz, equal to the `phase` register.
- `frame_start` out 1: one-clock pulse at each frame wrap.

## Operation

- **Framebuffer.** Simple dual-port RAM, 19200 x 3 bits. Address = y*160 + x, computed as {y,7'b0} + {y,5'b0} + x in 15 bits.
- RAM contents are not cleared by reset. In simulation they initialise to 0.
- **Write port.** Runs every clock, independent of `phase`. A write occurs when `writeEn` = 1 and x < 160 and y < 120. Out-of-range writes are dropped silently.
- **Pixel enable.** The `phase` register toggles every clock and is 0 after reset. `pix_en` = (`phase` == 1).
- **Counters.** `h` (10 bits, 0..799) advances only on `pix_en`. It wraps to 0 at 799. On that wrap, `v` (10 bits, 0..524) increments and wraps to 0 at 524.
- **Region decode, from counters:**
  - visible = (h < 640) && (v < 480).
  - hs_raw low for 656 <= h <= 751.
  - vs_raw low for 490 <= v <= 491.
- **Read address.** (v>>2)*160 + (h>>2), computed only when visible. Otherwise the address is don't-care and the colour output is forced to 0.
- **Pipeline.** On a `pix_en` edge:
  - RAM read data is registered and drives `vga_r/g/b`, gated by visible.
  - hs_raw, vs_raw and visible are registered in the same stage, so sync, blank and colour stay aligned.
- **Read-during-write** to the same address: the read returns the old data, and the write completes.
- **frame_start.** Registered. It is 1 for exactly the one clock after the edge at which the counters move from (799,524) to (0,0).

## Timing

- Reset (reset = 0 at a clock edge) gives, on the next cycle:
  - h = 0, v = 0, `phase` = 0.
  - `vga_hs` = 1, `vga_vs` = 1, `vga_blank_n` = 0.
  - `vga_r/g/b` = 0, `frame_start` = 0.
- Reset mid-line or mid-frame restarts the timing at (0,0) on the next cycle. No `frame_start` pulse is generated for this restart.
- Output latency: outputs for counter position (h,v) appear 1 pixel period (2 clocks) after the `pix_en` cycle at which the counters hold (h,v).
- Write-to-display latency: a write is visible on any scan that reads its address at least one clock after the write edge.
- Line period = 800 pixel periods = 1600 clocks. Frame period = 525 lines = 840000 clocks.
- hsync width = 96 pixel periods = 192 clocks. vsync width = 2 lines = 3200 clocks.
- `writeEn` held high for multiple clocks rewrites the same location each clock; this is harmless.

## Test plan

- **Reset values.** Hold reset = 0 for 3 clocks, then release. Required:
  - all outputs at their reset values;
  - first `frame_start` exactly 840000 clocks after release;
  - subsequent `frame_start` pulses every 840000 clocks.
- **Write and scan.** Write x=0, y=0, color=3'b100, then x=159, y=119, color=3'b011. Required:
  - `vga_r` = 8'hFF, `vga_g` = `vga_b` = 0 for screen pixels h 0..3, v 0..3;
  - pixels h 636..639, v 476..479 show r = 0, g = b = 8'hFF;
  - all other visible pixels are 0.
- **Out-of-range writes.** Write x=160, y=0 and x=0, y=120 with color=3'b111. Required:
  - no RAM location changes;
  - first pixel of row 1 (address 160) and last pixel of row 0 (address 159) still read 0.
- **Sync and blank timing.** Required:
  - `vga_hs` low for exactly 192 clocks per line, starting 2 clocks after h reaches 656;
  - `vga_vs` low for exactly 3200 clocks, starting with line 490;
  - `vga_blank_n` high for exactly 1280 clocks per visible line and low for all of lines 480..524.
- **Read-during-write.** Write color=3'b010 to address 0 on the same edge the scan reads (0,0). Required:
  - that pixel outputs the old value (0);
  - the same screen pixel outputs g = 8'hFF on the next frame.
- **Mid-frame reset.** Apply reset = 0 at v = 200. Required:
  - next cycle h = v = 0 and `vga_hs` = 1;
  - RAM contents are preserved, and previously written pixels reappear in the next frame.
